// File: rtl/qspi_pkg.sv
// Shared types and helpers for the multi-lane SPI slave.
package qspi_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    CMD,
    WRITE,
    READ
  } state_e;

  // Number of sclk rises needed to move one word across the lanes.
  function automatic int unsigned lane_bits_per_word(int unsigned word_w, int unsigned lanes);
    return word_w / lanes;
  endfunction

  // Bit of the command word that selects a read frame.
  function automatic int unsigned cmd_read_bit(int unsigned word_w);
    return word_w - 1;
  endfunction

endpackage

// File: rtl/qspi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, followed by an
// edge-detect flop producing single-cycle rise/fall strobes.
module qspi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("qspi_sync_edge: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus the previous-value flop used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/qspi_lane_slave.sv
// Multi-lane (1/2/4) SPI mode-0 slave, oversampled in the clk domain.
// First word of a frame is a command; its MSB selects read or write.
module qspi_lane_slave
  import qspi_pkg::*;
#(
  parameter int unsigned LANES       = 2,
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_ss,
  input  logic              io_sclk,
  input  logic [LANES-1:0]  io_qd_read,
  output logic [LANES-1:0]  io_qd_write,
  output logic [LANES-1:0]  io_qd_writeEnable,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_cmd,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              underflow,
  output logic              busy
);

  localparam int unsigned BPW          = lane_bits_per_word(WORD_W, LANES);
  localparam int unsigned CW           = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CMD_READ_BIT = cmd_read_bit(WORD_W);
  localparam logic [CW-1:0] LAST_CNT   = CW'(BPW - 1);

  if ((WORD_W % LANES) != 0) begin : g_bad_word
    $error("qspi_lane_slave: WORD_W must be a multiple of LANES");
  end
  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("qspi_lane_slave: LANES must be 1, 2 or 4");
  end

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;

  qspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (io_ss),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  qspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (io_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  logic [SYNC_STAGES-1:0][LANES-1:0] qd_dly_q;
  logic [LANES-1:0]                  qd_in;

  // Lane data delay line matching the sclk synchroniser depth.
  always_ff @(posedge clk) begin
    if (reset) qd_dly_q <= '0;
    else       qd_dly_q <= {qd_dly_q[SYNC_STAGES-2:0], io_qd_read};
  end

  assign qd_in = qd_dly_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] shift_in_q, shift_in_d;
  logic [WORD_W-1:0] shift_out_q, shift_out_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_cmd_q, rx_cmd_d;
  logic              tx_ready_q, tx_ready_d;
  logic              underflow_q, underflow_d;
  logic              oe_q, oe_d;
  logic [LANES-1:0]  qd_write_q, qd_write_d;
  logic              word_last;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_HIGH;
      bitcnt_q    <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_cmd_q    <= 1'b0;
      tx_ready_q  <= 1'b0;
      underflow_q <= 1'b0;
      oe_q        <= 1'b0;
      qd_write_q  <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_cmd_q    <= rx_cmd_d;
      tx_ready_q  <= tx_ready_d;
      underflow_q <= underflow_d;
      oe_q        <= oe_d;
      qd_write_q  <= qd_write_d;
    end
  end

  // Next-state, word assembly, tx load and lane drive.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_cmd_d    = 1'b0;
    tx_ready_d  = 1'b0;
    underflow_d = underflow_q;
    oe_d        = oe_q;
    qd_write_d  = qd_write_q;
    word_last   = (bitcnt_q == LAST_CNT);

    // The load request issued last cycle is consumed here.
    if (tx_ready_q) begin
      if (tx_valid) begin
        shift_out_d = tx_data;
      end else begin
        shift_out_d = '1;
        underflow_d = 1'b1;
      end
    end

    if (ss_rise) begin
      // Frame end takes priority over a coincident sclk edge.
      state_d    = IDLE;
      bitcnt_d   = '0;
      oe_d       = 1'b0;
      qd_write_d = '0;
    end else begin
      unique case (state_q)
        WAIT_HIGH: ;
        IDLE: begin
          if (ss_fall) begin
            state_d  = CMD;
            bitcnt_d = '0;
          end
        end
        CMD, WRITE: begin
          if (sclk_rise) begin
            shift_in_d = WORD_W'({shift_in_q, qd_in});
            if (word_last) begin
              bitcnt_d   = '0;
              rx_data_d  = shift_in_d;
              rx_valid_d = 1'b1;
              rx_cmd_d   = (state_q == CMD);
              if (state_q == CMD) begin
                if (shift_in_d[CMD_READ_BIT]) begin
                  state_d    = READ;
                  tx_ready_d = 1'b1;
                end else begin
                  state_d = WRITE;
                end
              end
            end else begin
              bitcnt_d = bitcnt_q + CW'(1);
            end
          end
        end
        READ: begin
          if (sclk_rise) begin
            if (word_last) begin
              bitcnt_d   = '0;
              tx_ready_d = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + CW'(1);
            end
          end
          if (sclk_fall) begin
            oe_d        = 1'b1;
            qd_write_d  = shift_out_q[WORD_W-1 -: LANES];
            shift_out_d = shift_out_q << LANES;
          end
        end
        default: state_d = WAIT_HIGH;
      endcase
    end
  end

  assign io_qd_write       = qd_write_q;
  assign io_qd_writeEnable = {LANES{oe_q}};
  assign rx_data           = rx_data_q;
  assign rx_valid          = rx_valid_q;
  assign rx_cmd            = rx_cmd_q;
  assign tx_ready          = tx_ready_q;
  assign underflow         = underflow_q;
  assign busy              = (state_q != IDLE) && (state_q != WAIT_HIGH);

endmodule

// File: tb/tb_qspi_lane_slave.sv
// Directed bench for qspi_lane_slave: five instances sharing sclk and a
// 4-bit master data bus, each with its own chip select.
module tb_qspi_lane_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] ss;
  logic       sclk;
  logic [3:0] mdata;

  // u0: LANES=2 WORD_W=8
  logic [1:0] qw0, oe0;
  logic [7:0] rxd0, txd0;
  logic       rxv0, rxc0, txv0, txr0, uf0, busy0;
  // u1: LANES=1 WORD_W=8
  logic       qw1, oe1;
  logic [7:0] rxd1;
  logic       rxv1, rxc1, txr1, uf1, busy1;
  // u2: LANES=4 WORD_W=8
  logic [3:0] qw2, oe2;
  logic [7:0] rxd2;
  logic       rxv2, rxc2, txr2, uf2, busy2;
  // u3: LANES=1 WORD_W=16
  logic        qw3, oe3;
  logic [15:0] rxd3;
  logic        rxv3, rxc3, txr3, uf3, busy3;
  // u4: LANES=4 WORD_W=16
  logic [3:0]  qw4, oe4;
  logic [15:0] rxd4;
  logic        rxv4, rxc4, txr4, uf4, busy4;

  logic [7:0]  tx_zero8  = '0;
  logic [15:0] tx_zero16 = '0;
  logic        tx_one    = 1'b1;

  qspi_lane_slave #(.LANES(2), .WORD_W(8), .SYNC_STAGES(2)) u0 (
    .clk(clk), .reset(reset), .io_ss(ss[0]), .io_sclk(sclk), .io_qd_read(mdata[1:0]),
    .io_qd_write(qw0), .io_qd_writeEnable(oe0), .rx_data(rxd0), .rx_valid(rxv0),
    .rx_cmd(rxc0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0),
    .underflow(uf0), .busy(busy0));

  qspi_lane_slave #(.LANES(1), .WORD_W(8), .SYNC_STAGES(2)) u1 (
    .clk(clk), .reset(reset), .io_ss(ss[1]), .io_sclk(sclk), .io_qd_read(mdata[0:0]),
    .io_qd_write(qw1), .io_qd_writeEnable(oe1), .rx_data(rxd1), .rx_valid(rxv1),
    .rx_cmd(rxc1), .tx_data(tx_zero8), .tx_valid(tx_one), .tx_ready(txr1),
    .underflow(uf1), .busy(busy1));

  qspi_lane_slave #(.LANES(4), .WORD_W(8), .SYNC_STAGES(2)) u2 (
    .clk(clk), .reset(reset), .io_ss(ss[2]), .io_sclk(sclk), .io_qd_read(mdata),
    .io_qd_write(qw2), .io_qd_writeEnable(oe2), .rx_data(rxd2), .rx_valid(rxv2),
    .rx_cmd(rxc2), .tx_data(tx_zero8), .tx_valid(tx_one), .tx_ready(txr2),
    .underflow(uf2), .busy(busy2));

  qspi_lane_slave #(.LANES(1), .WORD_W(16), .SYNC_STAGES(2)) u3 (
    .clk(clk), .reset(reset), .io_ss(ss[3]), .io_sclk(sclk), .io_qd_read(mdata[0:0]),
    .io_qd_write(qw3), .io_qd_writeEnable(oe3), .rx_data(rxd3), .rx_valid(rxv3),
    .rx_cmd(rxc3), .tx_data(tx_zero16), .tx_valid(tx_one), .tx_ready(txr3),
    .underflow(uf3), .busy(busy3));

  qspi_lane_slave #(.LANES(4), .WORD_W(16), .SYNC_STAGES(2)) u4 (
    .clk(clk), .reset(reset), .io_ss(ss[4]), .io_sclk(sclk), .io_qd_read(mdata),
    .io_qd_write(qw4), .io_qd_writeEnable(oe4), .rx_data(rxd4), .rx_valid(rxv4),
    .rx_cmd(rxc4), .tx_data(tx_zero16), .tx_valid(tx_one), .tx_ready(txr4),
    .underflow(uf4), .busy(busy4));

  // Received-word log from every instance.
  logic [15:0] q_data[$];
  logic        q_cmd[$];
  int          q_id[$];

  always @(negedge clk) begin
    if (rxv0) begin q_id.push_back(0); q_cmd.push_back(rxc0); q_data.push_back({8'h00, rxd0}); end
    if (rxv1) begin q_id.push_back(1); q_cmd.push_back(rxc1); q_data.push_back({8'h00, rxd1}); end
    if (rxv2) begin q_id.push_back(2); q_cmd.push_back(rxc2); q_data.push_back({8'h00, rxd2}); end
    if (rxv3) begin q_id.push_back(3); q_cmd.push_back(rxc3); q_data.push_back(rxd3); end
    if (rxv4) begin q_id.push_back(4); q_cmd.push_back(rxc4); q_data.push_back(rxd4); end
  end

  int txr_cnt = 0;
  int oe0_cnt = 0;
  always @(negedge clk) begin
    if (txr0)   txr_cnt++;
    if (oe0[0]) oe0_cnt++;
  end

  // Transmit stream feeding u0.
  logic [7:0] tx_words [4];
  int tx_idx = 0;
  always @(posedge clk) if (txr0 && txv0) tx_idx <= tx_idx + 1;
  assign txd0 = tx_words[tx_idx % 4];

  // Lane values of u0 seen by the master just before each sclk rise.
  logic [1:0] lane_s[$];
  logic       oe_s[$];

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic check_rx(input string name, input int id, input logic cmd, input logic [15:0] data);
    int          got_id;
    logic        got_cmd;
    logic [15:0] got_data;
    check({name, "_avail"}, 32'(q_data.size() != 0), 32'd1);
    if (q_data.size() != 0) begin
      got_id   = q_id.pop_front();
      got_cmd  = q_cmd.pop_front();
      got_data = q_data.pop_front();
      check(name, 32'({got_id[3:0], got_cmd, got_data}), 32'({id[3:0], cmd, data}));
    end
  endtask

  task automatic ss_low(input int id);
    ss[id] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_high(input int id);
    repeat (4) @(negedge clk);
    ss[id] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_group(input logic [3:0] g);
    mdata = g;
    repeat (4) @(negedge clk);
    lane_s.push_back(qw0);
    oe_s.push_back(oe0[0]);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Send the first ngroups lane groups of a word, most significant first.
  task automatic send_word(input int lanes, input int w, input logic [15:0] word, input int ngroups);
    logic [15:0] t;
    logic [3:0]  m;
    m = (lanes == 1) ? 4'h1 : (lanes == 2) ? 4'h3 : 4'hF;
    for (int g = 0; g < ngroups; g++) begin
      t = word >> (w - lanes * (g + 1));
      send_group(t[3:0] & m);
    end
  endtask

  initial begin
    int          base_tr, base_oe;
    logic [1:0]  exp_l [8];
    int          ids [4];
    int          lanesv [4];
    int          wv [4];
    logic [15:0] words [4];
    logic [15:0] mask;

    reset = 1'b1;
    ss    = '1;
    sclk  = 1'b0;
    mdata = '0;
    txv0  = 1'b1;
    for (int i = 0; i < 4; i++) tx_words[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_valid", 32'(rxv0), 32'd0);
    check("rst_rx_data", 32'(rxd0), 32'd0);
    check("rst_tx_ready", 32'(txr0), 32'd0);
    check("rst_underflow", 32'(uf0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_oe", 32'(oe0), 32'd0);
    check("rst_qd_write", 32'(qw0), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Write frame on u0: 0x12 (cmd), 0xA5, 0x3C
    base_tr = txr_cnt;
    base_oe = oe0_cnt;
    ss_low(0);
    send_word(2, 8, 16'h12, 4);
    check("wr_busy", 32'(busy0), 32'd1);
    send_word(2, 8, 16'hA5, 4);
    send_word(2, 8, 16'h3C, 4);
    ss_high(0);
    check_rx("wr_cmd", 0, 1'b1, 16'h12);
    check_rx("wr_d0", 0, 1'b0, 16'hA5);
    check_rx("wr_d1", 0, 1'b0, 16'h3C);
    check("wr_extra_rx", 32'(q_data.size()), 32'd0);
    check("wr_tx_ready_cnt", 32'(txr_cnt - base_tr), 32'd0);
    check("wr_oe_cycles", 32'(oe0_cnt - base_oe), 32'd0);
    check("wr_busy_end", 32'(busy0), 32'd0);

    // Read frame on u0: cmd 0x80, stream 0xC3, 0x5A
    tx_words[tx_idx % 4]       = 8'hC3;
    tx_words[(tx_idx + 1) % 4] = 8'h5A;
    tx_words[(tx_idx + 2) % 4] = 8'h00;
    lane_s.delete();
    oe_s.delete();
    base_tr = txr_cnt;
    ss_low(0);
    send_word(2, 8, 16'h80, 4);
    send_word(2, 8, 16'h00, 4);
    send_word(2, 8, 16'h00, 3);
    check("rd_tx_ready_cnt", 32'(txr_cnt - base_tr), 32'd2);
    send_word(2, 8, 16'h00, 1);
    ss_high(0);
    exp_l = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
    for (int i = 0; i < 8; i++)
      check($sformatf("rd_lane%0d", i), 32'(lane_s[4 + i]), 32'(exp_l[i]));
    check("rd_oe_during_cmd", 32'(oe_s[3]), 32'd0);
    check("rd_oe_first_fall", 32'(oe_s[4]), 32'd1);
    check_rx("rd_cmd", 0, 1'b1, 16'h80);
    check("rd_extra_rx", 32'(q_data.size()), 32'd0);
    check("rd_oe_end", 32'(oe0), 32'd0);
    check("rd_qd_write_end", 32'(qw0), 32'd0);
    check("rd_underflow", 32'(uf0), 32'd0);

    // Read frame with tx_valid low: all-ones word, sticky underflow
    txv0 = 1'b0;
    lane_s.delete();
    oe_s.delete();
    ss_low(0);
    send_word(2, 8, 16'h80, 4);
    send_word(2, 8, 16'h00, 4);
    ss_high(0);
    for (int i = 0; i < 4; i++)
      check($sformatf("uf_lane%0d", i), 32'(lane_s[4 + i]), 32'd3);
    check("uf_set", 32'(uf0), 32'd1);
    check_rx("uf_cmd", 0, 1'b1, 16'h80);
    txv0 = 1'b1;
    ss_low(0);
    send_word(2, 8, 16'h11, 4);
    send_word(2, 8, 16'h22, 4);
    ss_high(0);
    check("uf_sticky", 32'(uf0), 32'd1);
    check_rx("uf_wr_cmd", 0, 1'b1, 16'h11);
    check_rx("uf_wr_d0", 0, 1'b0, 16'h22);

    // Abort after 5 bits on u1 (LANES=1), then a clean frame
    ss_low(1);
    send_word(1, 8, 16'h40, 8);
    send_word(1, 8, 16'hFF, 5);
    ss_high(1);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_oe", 32'(oe1), 32'd0);
    check_rx("abort_cmd", 1, 1'b1, 16'h40);
    check("abort_no_partial", 32'(q_data.size()), 32'd0);
    ss_low(1);
    send_word(1, 8, 16'h01, 8);
    ss_high(1);
    check_rx("abort_next_cmd", 1, 1'b1, 16'h01);

    // One-cycle reset mid-frame on u0 while ss stays low
    ss_low(0);
    send_word(2, 8, 16'h05, 4);
    send_word(2, 8, 16'h77, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_underflow", 32'(uf0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    send_word(2, 8, 16'h07, 2);
    send_word(2, 8, 16'h66, 4);
    ss_high(0);
    check_rx("midrst_cmd", 0, 1'b1, 16'h05);
    check("midrst_no_rx", 32'(q_data.size()), 32'd0);
    ss_low(0);
    send_word(2, 8, 16'h34, 4);
    send_word(2, 8, 16'h99, 4);
    ss_high(0);
    check_rx("rearm_cmd", 0, 1'b1, 16'h34);
    check_rx("rearm_d0", 0, 1'b0, 16'h99);

    // Sweep LANES 1/4 x WORD_W 8/16 with random write frames
    ids    = '{1, 2, 3, 4};
    lanesv = '{1, 4, 1, 4};
    wv     = '{8, 8, 16, 16};
    for (int k = 0; k < 4; k++) begin
      mask = (wv[k] == 8) ? 16'h00FF : 16'hFFFF;
      for (int j = 0; j < 4; j++) words[j] = 16'($urandom) & mask;
      words[0] = words[0] & (mask >> 1);
      ss_low(ids[k]);
      for (int j = 0; j < 4; j++)
        send_word(lanesv[k], wv[k], words[j], wv[k] / lanesv[k]);
      ss_high(ids[k]);
      for (int j = 0; j < 4; j++)
        check_rx($sformatf("sweep_u%0d_w%0d", ids[k], j), ids[k], (j == 0), words[j]);
    end

    // ss and sclk rise together on the word-completing bit: bit dropped
    ss_low(4);
    send_word(4, 16, 16'h1234, 4);
    send_word(4, 16, 16'hBEEF, 3);
    mdata = 4'hF;
    repeat (4) @(negedge clk);
    sclk  = 1'b1;
    ss[4] = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    repeat (8) @(negedge clk);
    check_rx("tie_cmd", 4, 1'b1, 16'h1234);
    check("tie_dropped", 32'(q_data.size()), 32'd0);
    check("tie_busy", 32'(busy4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
